// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared FSM states, minimum legal ratio and duty half-length helper.
package clk_div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;

    localparam int MIN_DIV = 2;

    // N/2 for even N and (N-1)/2 for odd N are both a plain right shift
    function automatic logic [31:0] half_len(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter plus posedge/negedge duty flops producing a 50% divided clock.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] ratio,
    input  logic             run,
    input  logic             restart,
    output logic             period_end,
    output logic             div_clk
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] w_half;
    logic             r_clk_p;
    logic             r_clk_n;

    assign period_end = (r_cnt == ratio - DIV_W'(1));
    assign w_cnt_next = (restart || period_end) ? '0 : r_cnt + DIV_W'(1);
    assign w_half     = DIV_W'(half_len(32'(ratio)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_clk_p <= 1'b0;
        end else if (run) begin
            r_cnt   <= w_cnt_next;
            r_clk_p <= (w_cnt_next < w_half);
        end else begin
            r_cnt   <= '0;
            r_clk_p <= 1'b0;
        end
    end

    // odd ratios stretch the high phase by half a source period
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) r_clk_n <= 1'b0;
        else        r_clk_n <= ratio[0] & r_clk_p;
    end

    assign div_clk = r_clk_p | r_clk_n;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/stop and ratio-change control for the glitch-free 50% clock divider.
// Define CLKDIV_PERIOD_CNT_EN to add the period_cnt output.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             switch_done,
    output logic             div_active,
    output logic             div_clk
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    state_t           r_state;
    logic [DIV_W-1:0] r_cur_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_cfg_err;
    logic             r_switch_done;
    logic             w_xfer;
    logic             w_bad;
    logic             w_switch;
    logic             w_period_end;
    logic             w_run;
    logic             w_restart;

    assign cfg_ready   = (r_state == IDLE) || (r_state == RUN);
    assign w_xfer      = cfg_valid && cfg_ready;
    assign w_bad       = (cfg_div < DIV_W'(MIN_DIV));
    assign w_switch    = ((r_state == IDLE) && w_xfer && !w_bad) || ((r_state == PEND) && w_period_end);
    assign w_restart   = (r_state == IDLE) && en;
    assign w_run       = (r_state == IDLE) ? en : !((r_state == STOP) && !en && w_period_end);
    assign cfg_err     = r_cfg_err;
    assign switch_done = r_switch_done;
    assign div_active  = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cur_div     <= DIV_W'(DEF_DIV);
            r_pend_div    <= DIV_W'(DEF_DIV);
            r_cfg_err     <= 1'b0;
            r_switch_done <= 1'b0;
        end else begin
            r_cfg_err     <= w_xfer && w_bad;
            r_switch_done <= w_switch;
            case (r_state)
                IDLE: begin
                    if (w_xfer && !w_bad) r_cur_div <= cfg_div;
                    if (en) r_state <= RUN;
                end
                RUN: begin
                    if (w_xfer && !w_bad) begin
                        r_pend_div <= cfg_div;
                        r_state    <= PEND;
                    end else if (!en) begin
                        r_state <= STOP;
                    end
                end
                // the swap lands exactly on the boundary so no runt pulse appears
                PEND: begin
                    if (w_period_end) begin
                        r_cur_div <= r_pend_div;
                        r_state   <= en ? RUN : STOP;
                    end
                end
                STOP: begin
                    if (en) r_state <= RUN;
                    else if (w_period_end) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] r_period_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  r_period_cnt <= '0;
        else if (w_switch)                           r_period_cnt <= '0;
        else if (w_period_end && r_state != IDLE)    r_period_cnt <= r_period_cnt + 16'd1;
    end

    assign period_cnt = r_period_cnt;
`endif

    clk_div_core #(.DIV_W(DIV_W)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .ratio      (r_cur_div),
        .run        (w_run),
        .restart    (w_restart),
        .period_end (w_period_end),
        .div_clk    (div_clk)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed stimulus with queued expectations checked by an independent monitor.
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ready;
    logic       cfg_err;
    logic       switch_done;
    logic       div_active;
    logic       div_clk;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   hc = 0;
    int   t_rise = 0;
    bit   have_rise = 0;
    logic prev_dc = 1'b0;
    // high times and periods in half source cycles; pulses by posedge index
    int   q_high[$];
    int   q_per[$];
    int   q_sw[$];
    int   q_err[$];

    always #5 clk = ~clk;

    clk_div_ctrl #(.DIV_W(8), .DEF_DIV(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .switch_done (switch_done),
        .div_active  (div_active),
        .div_clk     (div_clk)
`ifdef CLKDIV_PERIOD_CNT_EN
        ,
        .period_cnt  (period_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        forever begin
            @(clk);
            #1;
            hc++;
            if (clk) begin
                cyc++;
                if (switch_done === 1'b1) begin
                    if (q_sw.size() == 0) unexpected("switch_done");
                    else chk("switch_done_cycle", cyc, q_sw.pop_front());
                end
                if (cfg_err === 1'b1) begin
                    if (q_err.size() == 0) unexpected("cfg_err");
                    else chk("cfg_err_cycle", cyc, q_err.pop_front());
                end
            end
            if (rst_n !== 1'b1) begin
                have_rise = 0;
            end else begin
                if (div_clk === 1'b1 && prev_dc === 1'b0) begin
                    if (have_rise) begin
                        if (q_per.size() == 0) unexpected("period");
                        else chk("period_hc", hc - t_rise, q_per.pop_front());
                    end
                    t_rise = hc;
                    have_rise = 1;
                end
                if (div_clk === 1'b0 && prev_dc === 1'b1) begin
                    if (q_high.size() == 0) unexpected("high");
                    else chk("high_hc", hc - t_rise, q_high.pop_front());
                end
                if (div_active === 1'b0) have_rise = 0;
            end
            prev_dc = div_clk;
        end
    end

    initial begin
        tick(2);
        chk("rst_div_clk", div_clk, 0);
        chk("rst_div_active", div_active, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_switch_done", switch_done, 0);
        rst_n = 1'b1;
        tick();
        // N=3 pulse, two N=4 pulses, N=5 pulse ending in stop, N=5 pulse without gap
        q_high.push_back(3); q_high.push_back(4); q_high.push_back(4);
        q_high.push_back(5); q_high.push_back(5);
        q_per.push_back(6); q_per.push_back(8); q_per.push_back(8); q_per.push_back(10);
        en = 1'b1;
        tick();
        chk("first_rise", div_clk, 1);
        chk("active_run", div_active, 1);
        cfg_valid = 1'b1;
        cfg_div = 8'd4;
        q_sw.push_back(cyc + 3);
        tick();
        chk("ready_pend", cfg_ready, 0);
        cfg_valid = 1'b0;
        tick(3);
        cfg_valid = 1'b1;
        cfg_div = 8'd1;
        q_err.push_back(cyc + 1);
        tick();
        chk("ready_after_err1", cfg_ready, 1);
        cfg_div = 8'd0;
        q_err.push_back(cyc + 1);
        tick();
        chk("ready_after_err0", cfg_ready, 1);
        cfg_valid = 1'b0;
        tick();
        cfg_valid = 1'b1;
        cfg_div = 8'd5;
        q_sw.push_back(cyc + 4);
        tick();
        cfg_valid = 1'b0;
        tick(4);
        en = 1'b0;
        tick(3);
        chk("stop_still_active", div_active, 1);
        tick();
        chk("stop_idle_active", div_active, 0);
        chk("stop_idle_clk", div_clk, 0);
        en = 1'b1;
        tick();
        chk("restart_active", div_active, 1);
        tick();
        en = 1'b0;
        tick(2);
        en = 1'b1;
        chk("stop_cancel_active", div_active, 1);
        tick(2);
        cfg_valid = 1'b1;
        cfg_div = 8'd4;
        tick();
        cfg_valid = 1'b0;
        chk("pre_reset_high", div_clk, 1);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("async_reset_clk", div_clk, 0);
        chk("async_reset_active", div_active, 0);
        tick(2);
        rst_n = 1'b1;
        tick();
        q_high.push_back(3); q_high.push_back(3); q_high.push_back(3);
        q_per.push_back(6); q_per.push_back(6);
        en = 1'b1;
        tick();
        chk("post_reset_rise", div_clk, 1);
        tick(6);
        en = 1'b0;
        tick(3);
        chk("post_reset_idle", div_active, 0);
`ifdef CLKDIV_PERIOD_CNT_EN
        chk("period_cnt_three", period_cnt, 3);
`endif
        // legal ratio together with en in IDLE, then switch plus en=0 in one RUN cycle
        q_high.push_back(2); q_high.push_back(2); q_high.push_back(255);
        q_per.push_back(4); q_per.push_back(4);
        cfg_valid = 1'b1;
        cfg_div = 8'd2;
        en = 1'b1;
        q_sw.push_back(cyc + 1);
        tick();
        cfg_valid = 1'b0;
        chk("idle_cfg_rise", div_clk, 1);
        tick(2);
        cfg_valid = 1'b1;
        cfg_div = 8'd255;
        en = 1'b0;
        q_sw.push_back(cyc + 2);
        tick();
        cfg_valid = 1'b0;
        chk("ready_pend_stop", cfg_ready, 0);
        tick(255);
        chk("n255_active", div_active, 1);
        tick();
        chk("n255_idle_active", div_active, 0);
        chk("n255_idle_clk", div_clk, 0);
`ifdef CLKDIV_PERIOD_CNT_EN
        chk("period_cnt_after_switch", period_cnt, 1);
`endif
        tick(3);
        chk("q_high_drained", q_high.size(), 0);
        chk("q_per_drained", q_per.size(), 0);
        chk("q_sw_drained", q_sw.size(), 0);
        chk("q_err_drained", q_err.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
